// File: rtl/vga_input_pkg.sv
// Shared encodings for the player-input scheduler: FSM states, direction bit
// positions and the opposing-direction resolver.
package vga_input_pkg;

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_OFFER   = 1'b1
    } state_t;

    localparam int unsigned DIR_UP    = 3;
    localparam int unsigned DIR_DOWN  = 2;
    localparam int unsigned DIR_LEFT  = 1;
    localparam int unsigned DIR_RIGHT = 0;

    // Cancels up+down and left+right pairs; diagonals pass through.
    function automatic logic [3:0] resolve_dir(input logic [3:0] pressed);
        logic [3:0] d;
        d = pressed;
        if (pressed[DIR_UP] && pressed[DIR_DOWN]) begin
            d[DIR_UP]   = 1'b0;
            d[DIR_DOWN] = 1'b0;
        end
        if (pressed[DIR_LEFT] && pressed[DIR_RIGHT]) begin
            d[DIR_LEFT]  = 1'b0;
            d[DIR_RIGHT] = 1'b0;
        end
        return d;
    endfunction

endpackage

// File: rtl/vga_input_sched_debounce.sv
// One input: 2-FF synchroniser, optional inversion, then a stability counter
// that moves the debounced level only after DEBOUNCE_CYC matching cycles.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 500000,
    parameter bit          ACTIVE_LOW   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYC + 1);

    logic [1:0]    sync;
    logic          synced;
    logic [CW-1:0] cnt;

    assign synced = ACTIVE_LOW ? ~sync[1] : sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            if (synced == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
                level <= synced;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/vga_input_sched.sv
// Frame-synchronous player-input scheduler: debounced buttons/shot are sampled
// once per vsync frame and offered to pixel_gen over a valid/ready handshake.
module vga_input_sched
    import vga_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC  = 500000,
    parameter int unsigned FIRE_COOLDOWN = 8,
    parameter int unsigned OVR_W         = 8
) (
    input  logic             clk_50MHz,
    input  logic             reset,
    input  logic [3:0]       btn_n,
    input  logic             shot,
    input  logic             vsync,
    input  logic             cmd_ready,
    output logic             cmd_valid,
    output logic [3:0]       cmd_dir,
    output logic             cmd_shot,
    output logic             frame_tick,
    output logic [OVR_W-1:0] overrun_cnt
);

    localparam int unsigned CDW = $clog2(FIRE_COOLDOWN + 1);

    logic [3:0]     pressed;
    logic [3:0]     dir;
    logic           shot_lvl;
    logic           shot_lvl_d;
    logic           shot_pend;
    logic [CDW-1:0] cooldown;
    logic [2:0]     vs;
    state_t         state, state_n;
    logic           accept;
    logic           accept_shot;
    logic           shot_sample;
    logic           sample_nz;

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .ACTIVE_LOW(1'b1)) u_btn (
            .clk   (clk_50MHz),
            .rst   (reset),
            .raw   (btn_n[i]),
            .level (pressed[i])
        );
    end

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .ACTIVE_LOW(1'b0)) u_shot (
        .clk   (clk_50MHz),
        .rst   (reset),
        .raw   (shot),
        .level (shot_lvl)
    );

    assign dir         = resolve_dir(pressed);
    assign cmd_valid   = (state == S_OFFER);
    assign accept      = cmd_valid && cmd_ready;
    assign accept_shot = accept && cmd_shot;
    // A shot being delivered this cycle must not be re-sampled into the next command.
    assign shot_sample = shot_pend && !accept_shot;
    assign sample_nz   = (dir != '0) || shot_sample;

    always_comb begin
        state_n = state;
        unique case (state)
            S_COLLECT: if (frame_tick && sample_nz) state_n = S_OFFER;
            S_OFFER:   if (accept) state_n = (frame_tick && sample_nz) ? S_OFFER : S_COLLECT;
            default:   state_n = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            state       <= S_COLLECT;
            vs          <= '0;
            frame_tick  <= 1'b0;
            shot_lvl_d  <= 1'b0;
            shot_pend   <= 1'b0;
            cooldown    <= '0;
            cmd_dir     <= '0;
            cmd_shot    <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            state      <= state_n;
            vs         <= {vs[1:0], vsync};
            frame_tick <= vs[2] && !vs[1];
            shot_lvl_d <= shot_lvl;

            if (accept_shot)
                shot_pend <= 1'b0;
            else if (shot_lvl && !shot_lvl_d && cooldown == '0)
                shot_pend <= 1'b1;

            if (accept_shot)
                cooldown <= CDW'(FIRE_COOLDOWN);
            else if (frame_tick && cooldown != '0)
                cooldown <= cooldown - CDW'(1);

            if (frame_tick && (state == S_COLLECT || accept)) begin
                cmd_dir  <= dir;
                cmd_shot <= shot_sample;
            end else if (frame_tick) begin
                cmd_dir  <= dir;
                cmd_shot <= cmd_shot | shot_pend;
                if (overrun_cnt != '1)
                    overrun_cnt <= overrun_cnt + OVR_W'(1);
            end else if (accept) begin
                cmd_dir  <= '0;
                cmd_shot <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vga_input_sched.sv
// Self-checking bench for vga_input_sched: table-driven direction vectors plus
// hand-written overrun, shot-cooldown, reset and saturation sequences.
module tb_vga_input_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_n;
    logic       shot;
    logic       vsync;
    logic       cmd_ready;
    logic       cmd_valid;
    logic [3:0] cmd_dir;
    logic       cmd_shot;
    logic       frame_tick;
    logic [7:0] overrun_cnt;

    int tests = 0;
    int fails = 0;

    logic [4:0] exp_q[$];

    typedef struct {
        logic [3:0] btn_n;
        logic [3:0] exp_dir;
    } vec_t;

    vec_t vecs[8];

    vga_input_sched #(
        .DEBOUNCE_CYC  (8),
        .FIRE_COOLDOWN (2),
        .OVR_W         (8)
    ) dut (
        .clk_50MHz   (clk),
        .reset       (rst),
        .btn_n       (btn_n),
        .shot        (shot),
        .vsync       (vsync),
        .cmd_ready   (cmd_ready),
        .cmd_valid   (cmd_valid),
        .cmd_dir     (cmd_dir),
        .cmd_shot    (cmd_shot),
        .frame_tick  (frame_tick),
        .overrun_cnt (overrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame();
        vsync = 1'b0;
        tick(3);
        vsync = 1'b1;
        tick(5);
    endtask

    task automatic shot_pulse();
        shot = 1'b1;
        tick(15);
        shot = 1'b0;
        tick(15);
    endtask

    // Scoreboard: every completed handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && cmd_valid && cmd_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_cmd", {27'd0, cmd_dir, cmd_shot}, 32'h1f);
            end else begin
                logic [4:0] e;
                e = exp_q.pop_front();
                check("cmd_payload", {27'd0, cmd_dir, cmd_shot}, {27'd0, e});
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{btn_n: 4'b0111, exp_dir: 4'b1000};
        vecs[1] = '{btn_n: 4'b0110, exp_dir: 4'b1001};
        vecs[2] = '{btn_n: 4'b0010, exp_dir: 4'b0001};
        vecs[3] = '{btn_n: 4'b1111, exp_dir: 4'b0000};
        vecs[4] = '{btn_n: 4'b1100, exp_dir: 4'b0000};
        vecs[5] = '{btn_n: 4'b0000, exp_dir: 4'b0000};
        vecs[6] = '{btn_n: 4'b1010, exp_dir: 4'b0101};
        vecs[7] = '{btn_n: 4'b1101, exp_dir: 4'b0010};

        rst = 1'b1; btn_n = 4'hF; shot = 1'b0; vsync = 1'b1; cmd_ready = 1'b1;
        tick(3);
        check("rst_valid", {31'd0, cmd_valid}, 0);
        check("rst_dir", {28'd0, cmd_dir}, 0);
        check("rst_shot", {31'd0, cmd_shot}, 0);
        check("rst_tick", {31'd0, frame_tick}, 0);
        check("rst_ovr", {24'd0, overrun_cnt}, 0);
        rst = 1'b0;
        tick(20);

        // Bouncing up button: a frame during the bounce yields nothing.
        for (int i = 0; i < 3; i++) begin
            btn_n[3] = 1'b0; tick(3);
            btn_n[3] = 1'b1; tick(3);
        end
        btn_n[3] = 1'b0;
        frame();
        check("bounce_no_cmd", {31'd0, cmd_valid}, 0);
        tick(12);
        exp_q.push_back({4'b1000, 1'b0});
        vsync = 1'b0;
        tick(3);
        check("lat_not_yet", {31'd0, cmd_valid}, 0);
        check("lat_tick", {31'd0, frame_tick}, 1);
        tick(1);
        check("lat_valid", {31'd0, cmd_valid}, 1);
        check("lat_dir", {28'd0, cmd_dir}, 32'h8);
        vsync = 1'b1;
        tick(4);
        check("bounce_drain", exp_q.size(), 0);

        for (int i = 0; i < 8; i++) begin
            btn_n = vecs[i].btn_n;
            tick(20);
            if (vecs[i].exp_dir != 4'b0000)
                exp_q.push_back({vecs[i].exp_dir, 1'b0});
            frame();
            check($sformatf("vec%0d_drain", i), exp_q.size(), 0);
            check($sformatf("vec%0d_idle", i), {31'd0, cmd_valid}, 0);
        end

        // Overrun: left held, ready low across three frames.
        cmd_ready = 1'b0;
        exp_q.push_back({4'b0010, 1'b0});
        repeat (3) frame();
        check("ovr_valid", {31'd0, cmd_valid}, 1);
        check("ovr_dir", {28'd0, cmd_dir}, 32'h2);
        check("ovr_cnt", {24'd0, overrun_cnt}, 2);
        cmd_ready = 1'b1;
        tick(1);
        check("ovr_accept_drop", {31'd0, cmd_valid}, 0);
        check("ovr_drain", exp_q.size(), 0);

        // frame_tick coinciding with ready: old accepted, new offered next cycle.
        cmd_ready = 1'b0;
        exp_q.push_back({4'b0010, 1'b0});
        frame();
        btn_n = 4'b0111;
        tick(20);
        exp_q.push_back({4'b1000, 1'b0});
        vsync = 1'b0;
        tick(3);
        cmd_ready = 1'b1;
        check("coin_tick", {31'd0, frame_tick}, 1);
        tick(1);
        check("coin_valid", {31'd0, cmd_valid}, 1);
        check("coin_dir", {28'd0, cmd_dir}, 32'h8);
        check("coin_ovr", {24'd0, overrun_cnt}, 2);
        vsync = 1'b1;
        tick(5);
        check("coin_drain", exp_q.size(), 0);

        // Shot cooldown: frame-2/3 edges dropped, later edge delivered.
        btn_n = 4'hF;
        tick(20);
        shot_pulse();
        exp_q.push_back({4'b0000, 1'b1});
        frame();
        check("shot1_drain", exp_q.size(), 0);
        shot_pulse();
        frame();
        shot_pulse();
        frame();
        check("shot_dropped", exp_q.size(), 0);
        shot_pulse();
        exp_q.push_back({4'b0000, 1'b1});
        frame();
        check("shot2_drain", exp_q.size(), 0);
        repeat (2) frame();

        // Reset while offering a shot command.
        cmd_ready = 1'b0;
        btn_n = 4'b0111;
        shot_pulse();
        frame();
        check("pre_rst_valid", {31'd0, cmd_valid}, 1);
        check("pre_rst_shot", {31'd0, cmd_shot}, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, cmd_valid}, 0);
        check("mid_rst_dir", {28'd0, cmd_dir}, 0);
        check("mid_rst_shot", {31'd0, cmd_shot}, 0);
        check("mid_rst_tick", {31'd0, frame_tick}, 0);
        check("mid_rst_ovr", {24'd0, overrun_cnt}, 0);
        tick(2);
        rst = 1'b0;
        cmd_ready = 1'b1;
        tick(3);
        frame();
        check("post_rst_no_cmd", {31'd0, cmd_valid}, 0);
        tick(20);
        exp_q.push_back({4'b1000, 1'b0});
        frame();
        check("post_rst_drain", exp_q.size(), 0);

        // Saturation of the overrun counter.
        cmd_ready = 1'b0;
        exp_q.push_back({4'b1000, 1'b0});
        repeat (300) frame();
        check("sat_cnt", {24'd0, overrun_cnt}, 255);
        check("sat_valid", {31'd0, cmd_valid}, 1);
        cmd_ready = 1'b1;
        tick(2);
        check("sat_drain", exp_q.size(), 0);
        check("sat_hold", {24'd0, overrun_cnt}, 255);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
